// File: rtl/rv32i_opcodes_pkg.sv
// Shared RV32I decode/writeback types.
//   regfile_load_t : select for the register-file write-data mux
//   wb_entry_t     : one buffered execute result awaiting the write port
package rv32i_opcodes;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FROM_ALU       = 2'd0,
        FROM_MEM       = 2'd1,
        FROM_PC_PLUS_4 = 2'd2
    } regfile_load_t;

    typedef struct packed {
        logic [4:0]      rd;
        regfile_load_t   src;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of producer-side inputs and register-file-side outputs of the
// writeback arbiter.
//   master : the execute stage / load unit / register file environment
//   slave  : the arbiter itself
// Execute side: exec_valid/exec_ready handshake, exec_rd, exec_src, alu_out, pc_d
// Load side   : ld_valid (no backpressure), ld_rd, mem_rd_data
// Write port  : wr_en, wr_addr, wr_sel, wr_alu, wr_mem, wr_pc
// Status      : pending (buffer occupancy 0..DEPTH)
interface regfile_wb_arbiter_if
    import rv32i_opcodes::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    logic                     exec_valid;
    logic                     exec_ready;
    logic [4:0]               exec_rd;
    regfile_load_t            exec_src;
    logic [WIDTH-1:0]         alu_out;
    logic [WIDTH-1:0]         pc_d;
    logic                     ld_valid;
    logic [4:0]               ld_rd;
    logic [WIDTH-1:0]         mem_rd_data;
    logic                     wr_en;
    logic [4:0]               wr_addr;
    regfile_load_t            wr_sel;
    logic [WIDTH-1:0]         wr_alu;
    logic [WIDTH-1:0]         wr_mem;
    logic [WIDTH-1:0]         wr_pc;
    logic [$clog2(DEPTH):0]   pending;

    modport master (
        output exec_valid, exec_rd, exec_src, alu_out, pc_d,
        output ld_valid, ld_rd, mem_rd_data,
        input  exec_ready, wr_en, wr_addr, wr_sel, wr_alu, wr_mem, wr_pc, pending
    );

    modport slave (
        input  exec_valid, exec_rd, exec_src, alu_out, pc_d,
        input  ld_valid, ld_rd, mem_rd_data,
        output exec_ready, wr_en, wr_addr, wr_sel, wr_alu, wr_mem, wr_pc, pending
    );
endinterface

// File: rtl/regfile_wb_pending_fifo.sv
// In-order holding buffer for execute results that lost the write port.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata (head entry,
// valid whenever !empty), count (0..DEPTH), full, empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_pending_fifo
    import rv32i_opcodes::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              wdata,
    input  logic                   pop,
    output wb_entry_t              rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [PW:0]      count_q;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves
    // the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rdPtr_q];
    assign count = count_q;
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the load unit and the execute
// stage. Loads always win; losing execute results wait in an in-order
// pending buffer. One registered write per cycle.
// Ports: clk, rst (sync, active-high), bus (regfile_wb_arbiter_if.slave),
// carrying the execute handshake, load return, write port and occupancy.
module regfile_wb_arbiter
    import rv32i_opcodes::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    logic [$clog2(DEPTH):0] fifoCount;
    logic                   fifoFull;
    logic                   fifoEmpty;
    wb_entry_t              headEntry;
    wb_entry_t              enqEntry;
    logic                   push;
    logic                   pop;

    logic                   execReady;
    logic                   execAccept;
    logic                   execLive;
    logic                   ldLive;
    logic                   issueHead;
    logic                   issueExec;
    regfile_load_t          execSrc;
    logic [WIDTH-1:0]       execWord;

    logic                   wrEn_q,   wrEn_d;
    logic [4:0]             wrAddr_q, wrAddr_d;
    regfile_load_t          wrSel_q,  wrSel_d;
    logic [WIDTH-1:0]       wrAlu_q,  wrAlu_d;
    logic [WIDTH-1:0]       wrMem_q,  wrMem_d;
    logic [WIDTH-1:0]       wrPc_q,   wrPc_d;

    wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enqEntry),
        .pop   (pop),
        .rdata (headEntry),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // Issue selection: load > buffer head > direct bypass of a fresh execute
    // result. rd==0 results are accepted but never written. An illegal
    // FROM_MEM execute source degrades to FROM_ALU.
    always_comb begin
        execReady  = !fifoFull;
        execAccept = bus.exec_valid && execReady;
        execLive   = execAccept && (bus.exec_rd != 5'd0);
        ldLive     = bus.ld_valid && (bus.ld_rd != 5'd0);
        execSrc    = (bus.exec_src == FROM_PC_PLUS_4) ? FROM_PC_PLUS_4 : FROM_ALU;
        execWord   = (execSrc == FROM_PC_PLUS_4) ? bus.pc_d : bus.alu_out;
        issueHead  = !ldLive && !fifoEmpty;
        issueExec  = !ldLive && fifoEmpty && execLive;
        push       = execLive && !issueExec;
        pop        = issueHead;
        enqEntry   = '{rd: bus.exec_rd, src: execSrc, data: XLEN'(execWord)};

        wrEn_d   = ldLive || issueHead || issueExec;
        wrAddr_d = wrAddr_q;
        wrSel_d  = wrSel_q;
        wrAlu_d  = wrAlu_q;
        wrMem_d  = wrMem_q;
        wrPc_d   = wrPc_q;
        if (ldLive) begin
            wrAddr_d = bus.ld_rd;
            wrSel_d  = FROM_MEM;
            wrMem_d  = bus.mem_rd_data;
        end else if (issueHead) begin
            wrAddr_d = headEntry.rd;
            wrSel_d  = headEntry.src;
            if (headEntry.src == FROM_PC_PLUS_4) begin
                wrPc_d = WIDTH'(headEntry.data);
            end else begin
                wrAlu_d = WIDTH'(headEntry.data);
            end
        end else if (issueExec) begin
            wrAddr_d = bus.exec_rd;
            wrSel_d  = execSrc;
            if (execSrc == FROM_PC_PLUS_4) begin
                wrPc_d = execWord;
            end else begin
                wrAlu_d = execWord;
            end
        end
    end

    // Write-port output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrEn_q   <= 1'b0;
            wrAddr_q <= 5'd0;
            wrSel_q  <= FROM_ALU;
            wrAlu_q  <= '0;
            wrMem_q  <= '0;
            wrPc_q   <= '0;
        end else begin
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrSel_q  <= wrSel_d;
            wrAlu_q  <= wrAlu_d;
            wrMem_q  <= wrMem_d;
            wrPc_q   <= wrPc_d;
        end
    end

    // The execute stage must never claim a memory source.
    always_ff @(posedge clk) begin
        if (!rst && execAccept) begin
            assert (bus.exec_src != FROM_MEM);
        end
    end

    assign bus.exec_ready = execReady;
    assign bus.pending    = fifoCount;
    assign bus.wr_en      = wrEn_q;
    assign bus.wr_addr    = wrAddr_q;
    assign bus.wr_sel     = wrSel_q;
    assign bus.wr_alu     = wrAlu_q;
    assign bus.wr_mem     = wrMem_q;
    assign bus.wr_pc      = wrPc_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_regfile_wb_arbiter;
    import rv32i_opcodes::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    typedef struct {
        int            rd;
        regfile_load_t src;
        logic [31:0]   data;
    } model_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: pending results and the last written operands.
    model_entry_t  mq[$];
    logic          eWrEn;
    logic [4:0]    eAddr;
    regfile_load_t eSel;
    logic [31:0]   eAlu, eMem, ePc;

    regfile_wb_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Drive all producer inputs inactive.
    task automatic idle();
        bus.exec_valid  = 1'b0;
        bus.exec_rd     = 5'd0;
        bus.exec_src    = FROM_ALU;
        bus.alu_out     = '0;
        bus.pc_d        = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = 5'd0;
        bus.mem_rd_data = '0;
    endtask

    // Advance one clock and update the model from the inputs present at the
    // edge; returns #1 after the edge so outputs can be sampled.
    task automatic step();
        bit            acc, ldl, exl;
        regfile_load_t s;
        logic [31:0]   w;
        model_entry_t  e;
        acc = bus.exec_valid && (mq.size() < DEPTH);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            eWrEn = 0; eAddr = 0; eSel = FROM_ALU; eAlu = 0; eMem = 0; ePc = 0;
        end else begin
            ldl = bus.ld_valid && (bus.ld_rd != 0);
            exl = acc && (bus.exec_rd != 0);
            s   = (bus.exec_src == FROM_PC_PLUS_4) ? FROM_PC_PLUS_4 : FROM_ALU;
            w   = (s == FROM_PC_PLUS_4) ? bus.pc_d : bus.alu_out;
            eWrEn = 1;
            if (ldl) begin
                eAddr = bus.ld_rd; eSel = FROM_MEM; eMem = bus.mem_rd_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                eAddr = 5'(e.rd); eSel = e.src;
                if (e.src == FROM_PC_PLUS_4) ePc = e.data; else eAlu = e.data;
            end else if (exl) begin
                eAddr = bus.exec_rd; eSel = s;
                if (s == FROM_PC_PLUS_4) ePc = w; else eAlu = w;
                exl = 0;
            end else begin
                eWrEn = 0;
            end
            if (exl) mq.push_back('{rd: int'(bus.exec_rd), src: s, data: w});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %0h expected 0", bus.wr_en); end
        checks++; if (bus.wr_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %0h expected 0", bus.wr_addr); end
        checks++; if (bus.wr_sel !== FROM_ALU) begin errors++; $display("[TB] FAIL reset_wr_sel: got %0h expected 0", bus.wr_sel); end
        checks++; if ({bus.wr_alu, bus.wr_mem, bus.wr_pc} !== '0) begin errors++; $display("[TB] FAIL reset_operands: got %0h/%0h/%0h expected 0", bus.wr_alu, bus.wr_mem, bus.wr_pc); end
        checks++; if (bus.pending !== '0) begin errors++; $display("[TB] FAIL reset_pending: got %0d expected 0", bus.pending); end
        rst = 1'b0;
        checks++; if (bus.exec_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_exec_ready: got %0h expected 1", bus.exec_ready); end
    endtask

    task automatic test_bypass();
        idle();
        bus.exec_valid = 1'b1; bus.exec_rd = 5'd5; bus.exec_src = FROM_ALU; bus.alu_out = 32'h1234;
        step();
        idle();
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5) begin errors++; $display("[TB] FAIL bypass_write: got en=%0h addr=%0d expected en=1 addr=5", bus.wr_en, bus.wr_addr); end
        checks++; if (bus.wr_sel !== FROM_ALU || bus.wr_alu !== 32'h1234) begin errors++; $display("[TB] FAIL bypass_data: got sel=%0h alu=%0h expected sel=0 alu=1234", bus.wr_sel, bus.wr_alu); end
        checks++; if (bus.pending !== '0) begin errors++; $display("[TB] FAIL bypass_pending: got %0d expected 0", bus.pending); end
        step();
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL bypass_idle: got %0h expected 0", bus.wr_en); end
    endtask

    task automatic test_collision();
        idle();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.mem_rd_data = 32'hAAAA;
        bus.exec_valid = 1'b1; bus.exec_rd = 5'd7; bus.exec_src = FROM_PC_PLUS_4; bus.pc_d = 32'h104;
        step();
        idle();
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3 || bus.wr_sel !== FROM_MEM || bus.wr_mem !== 32'hAAAA) begin errors++; $display("[TB] FAIL collision_load: got en=%0h addr=%0d sel=%0h mem=%0h expected 1/3/1/aaaa", bus.wr_en, bus.wr_addr, bus.wr_sel, bus.wr_mem); end
        checks++; if (bus.pending !== 2'd1) begin errors++; $display("[TB] FAIL collision_pending: got %0d expected 1", bus.pending); end
        step();
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7 || bus.wr_sel !== FROM_PC_PLUS_4 || bus.wr_pc !== 32'h104) begin errors++; $display("[TB] FAIL collision_exec: got en=%0h addr=%0d sel=%0h pc=%0h expected 1/7/2/104", bus.wr_en, bus.wr_addr, bus.wr_sel, bus.wr_pc); end
        checks++; if (bus.pending !== '0) begin errors++; $display("[TB] FAIL collision_drain: got %0d expected 0", bus.pending); end
    endtask

    task automatic test_backpressure();
        int nextRd = 1;
        int seen[$];
        bit accepted;
        for (int c = 0; c < 9; c++) begin
            idle();
            bus.ld_valid    = (c < 4);
            bus.ld_rd       = 5'(10 + c);
            bus.mem_rd_data = $urandom;
            bus.exec_valid  = (nextRd <= 3);
            bus.exec_rd     = 5'(nextRd);
            bus.alu_out     = 32'h100 + nextRd;
            #0;
            if (c == 2 || c == 3) begin
                checks++; if (bus.exec_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low_c%0d: got %0h expected 0", c, bus.exec_ready); end
            end
            accepted = bus.exec_valid && bus.exec_ready;
            step();
            if (accepted) nextRd++;
            if (bus.wr_en === 1'b1 && bus.wr_addr < 5'd10) begin
                seen.push_back(int'(bus.wr_addr));
                checks++; if (bus.wr_alu !== 32'h100 + bus.wr_addr) begin errors++; $display("[TB] FAIL bp_data: got %0h expected %0h", bus.wr_alu, 32'h100 + bus.wr_addr); end
            end
        end
        idle();
        checks++; if (seen.size() != 3) begin errors++; $display("[TB] FAIL bp_count: got %0d writes expected 3", seen.size()); end
        for (int i = 0; i < seen.size() && i < 3; i++) begin
            checks++; if (seen[i] != i + 1) begin errors++; $display("[TB] FAIL bp_order_%0d: got x%0d expected x%0d", i, seen[i], i + 1); end
        end
    endtask

    task automatic test_rd_zero();
        idle();
        bus.exec_valid = 1'b1; bus.exec_rd = 5'd0; bus.alu_out = 32'hDEAD;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.mem_rd_data = 32'hBEEF;
        step();
        idle();
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL rd0_wr_en: got %0h expected 0", bus.wr_en); end
        checks++; if (bus.pending !== '0) begin errors++; $display("[TB] FAIL rd0_pending: got %0d expected 0", bus.pending); end
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c < 2; c++) begin
            idle();
            bus.ld_valid = 1'b1; bus.ld_rd = 5'(10 + c); bus.mem_rd_data = $urandom;
            bus.exec_valid = 1'b1; bus.exec_rd = 5'(20 + c); bus.alu_out = $urandom;
            step();
        end
        idle();
        checks++; if (bus.pending !== 2'd2) begin errors++; $display("[TB] FAIL midrst_full: got %0d expected 2", bus.pending); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.pending !== '0 || bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_clear: got pending=%0d en=%0h expected 0/0", bus.pending, bus.wr_en); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale_write: got en=%0h addr=%0d expected no write", bus.wr_en, bus.wr_addr); end
        end
    endtask

    task automatic test_stream();
        logic [31:0] v;
        for (int i = 0; i < 10; i++) begin
            idle();
            v = $urandom;
            bus.exec_valid = 1'b1; bus.exec_rd = 5'(1 + i); bus.alu_out = v;
            step();
            checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(1 + i) || bus.wr_alu !== v || bus.pending !== '0) begin errors++; $display("[TB] FAIL stream_%0d: got en=%0h addr=%0d alu=%0h pend=%0d expected 1/%0d/%0h/0", i, bus.wr_en, bus.wr_addr, bus.wr_alu, bus.pending, 1 + i, v); end
        end
        idle();
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst             = ($urandom_range(0, 99) == 0);
            bus.ld_valid    = ($urandom_range(0, 99) < 40);
            bus.ld_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.mem_rd_data = $urandom;
            bus.exec_valid  = ($urandom_range(0, 99) < 60);
            bus.exec_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.exec_src    = $urandom_range(0, 1) ? FROM_PC_PLUS_4 : FROM_ALU;
            bus.alu_out     = $urandom;
            bus.pc_d        = $urandom;
            #0;
            checks++; if (bus.exec_ready !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rand_ready_%0d: got %0h expected %0h", c, bus.exec_ready, mq.size() < DEPTH); end
            step();
            checks++;
            if (bus.wr_en !== eWrEn || bus.wr_addr !== eAddr || bus.wr_sel !== eSel ||
                bus.wr_alu !== eAlu || bus.wr_mem !== eMem || bus.wr_pc !== ePc ||
                bus.pending !== 2'(mq.size())) begin
                errors++;
                $display("[TB] FAIL rand_out_%0d: got en=%0h a=%0d s=%0h alu=%0h mem=%0h pc=%0h p=%0d expected en=%0h a=%0d s=%0h alu=%0h mem=%0h pc=%0h p=%0d",
                         c, bus.wr_en, bus.wr_addr, bus.wr_sel, bus.wr_alu, bus.wr_mem, bus.wr_pc, bus.pending,
                         eWrEn, eAddr, eSel, eAlu, eMem, ePc, mq.size());
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_collision();
        test_backpressure();
        test_rd_zero();
        test_reset_midop();
        test_stream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
